// File: rtl/serial_tx_shifter.sv
// Parallel-in, serial-out link transmitter with its own SCK, FRAME and DONE.
// Optional macro SERIAL_TX_PARITY_EN appends one even-parity bit after the data bits.
module serial_tx_shifter #(
  parameter int DATA_W    = 8,
  parameter int DIV       = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              CLK,
  input  logic              CLR_N,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic              TX_VALID,
  output logic              TX_READY,
  output logic              SCK,
  output logic              SDO,
  output logic              FRAME,
  output logic              DONE
);

`ifdef SERIAL_TX_PARITY_EN
  localparam int NBITS = DATA_W + 1;
`else
  localparam int NBITS = DATA_W;
`endif
  localparam int BW = $clog2(NBITS + 1);
  localparam int DW = $clog2(DIV + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t           state, state_nx;
  logic [NBITS-1:0] shreg, shreg_nx, load_word, shifted;
  logic [BW-1:0]    bit_cnt, bit_cnt_nx;
  logic [DW-1:0]    div_cnt, div_cnt_nx;
  logic             sck_nx, sdo_nx, frame_nx, done_nx;

  function automatic logic first_bit(input logic [NBITS-1:0] word);
    return MSB_FIRST ? word[NBITS-1] : word[0];
  endfunction

  // The shift register holds the frame in transmit order, parity included.
  always_comb begin
`ifdef SERIAL_TX_PARITY_EN
    load_word = MSB_FIRST ? {TX_DATA, ^TX_DATA} : {^TX_DATA, TX_DATA};
`else
    load_word = TX_DATA;
`endif
    shifted = MSB_FIRST ? {shreg[NBITS-2:0], 1'b0} : {1'b0, shreg[NBITS-1:1]};
  end

  assign TX_READY = (state == IDLE);

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_nx   = state;
    shreg_nx   = shreg;
    bit_cnt_nx = bit_cnt;
    div_cnt_nx = div_cnt;
    sck_nx     = SCK;
    sdo_nx     = SDO;
    frame_nx   = FRAME;
    done_nx    = 1'b0;
    unique case (state)
      IDLE: begin
        if (TX_VALID) begin
          state_nx   = SHIFT;
          shreg_nx   = load_word;
          sdo_nx     = first_bit(load_word);
          sck_nx     = 1'b1;
          frame_nx   = 1'b1;
          bit_cnt_nx = '0;
          div_cnt_nx = '0;
        end
      end
      SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_nx = '0;
          if (SCK) begin
            sck_nx = 1'b0;
          end else if (bit_cnt == BIT_LAST) begin
            state_nx   = GAP;
            frame_nx   = 1'b0;
            sdo_nx     = 1'b0;
            shreg_nx   = '0;
            bit_cnt_nx = '0;
          end else begin
            // Rising SCK launches the next bit in the same cycle.
            sck_nx     = 1'b1;
            shreg_nx   = shifted;
            sdo_nx     = first_bit(shifted);
            bit_cnt_nx = bit_cnt + 1'b1;
          end
        end else begin
          div_cnt_nx = div_cnt + 1'b1;
        end
      end
      GAP: begin
        if (div_cnt == DIV_LAST) begin
          state_nx   = IDLE;
          div_cnt_nx = '0;
          done_nx    = 1'b1;
        end else begin
          div_cnt_nx = div_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the comb block above uses blocking.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      SCK     <= 1'b0;
      SDO     <= 1'b0;
      FRAME   <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      state   <= state_nx;
      shreg   <= shreg_nx;
      bit_cnt <= bit_cnt_nx;
      div_cnt <= div_cnt_nx;
      SCK     <= sck_nx;
      SDO     <= sdo_nx;
      FRAME   <= frame_nx;
      DONE    <= done_nx;
    end
  end

endmodule

// File: doc/serial_tx_shifter.md
Name: serial_tx_shifter

Overview:
- Parallel-in, serial-out transmitter that drives the launching side of a serial link.
- Accepts a DATA_W-bit word on a valid/ready handshake and generates its own serial clock SCK.
- Shifts the word out on SDO with FRAME asserted for the whole transfer.
- SDO changes on SCK rising edges, so a falling-edge-capture flip-flop at the far end samples mid-bit.

Parameters:
- DATA_W, 8, width of TX_DATA and number of data bits per frame.
- DIV, 4, CLK cycles per SCK half-period; legal range DIV >= 1.
- MSB_FIRST, 1, 1 = TX_DATA[DATA_W-1] sent first; 0 = TX_DATA[0] sent first.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- CLR_N  input  1  asynchronous active-low reset.
- TX_DATA  input  DATA_W  word to send; sampled only on handshake.
- TX_VALID  input  1  word available.
- TX_READY  output  1  block can accept a word.
- SCK  output  1  generated serial clock.
- SDO  output  1  serial data.
- FRAME  output  1  high for the duration of a transfer.
- DONE  output  1  one-cycle pulse when a transfer completes.

Behaviour:
- Reset: one clock; CLR_N is asynchronous, active-low. While CLR_N=0 the block holds these values:
  - state=IDLE, TX_READY=1, SCK=0, SDO=0, FRAME=0, DONE=0
  - shift register, bit counter and divider counter all 0
- Reset asserted mid-transfer aborts immediately; the word is discarded and no DONE is issued.
- Handshake:
  - Accept occurs on a CLK edge with TX_VALID=1 and TX_READY=1. TX_READY=1 only in IDLE.
  - On accept: TX_DATA is latched; the next state is SHIFT with FRAME=1, SCK=1 and SDO=first bit.
  - TX_DATA changes after accept have no effect.
- States:
  - IDLE: outputs at reset values, except DONE as described below. Go to SHIFT on accept.
  - SHIFT:
    - Divider counts 0..DIV-1; at DIV-1 it wraps and SCK toggles.
    - On a high->low toggle, SCK falls; SDO holds.
    - On a low->high toggle that is not the last bit: SCK rises, the shift register advances and SDO presents the next bit in the same cycle; bit_cnt increments.
    - On the low->high toggle after the last bit (bit_cnt = NBITS-1): go to GAP instead; SCK stays 0.
  - GAP: FRAME=0, SCK=0, SDO=0 for DIV cycles, then go to IDLE. DONE=1 in the first IDLE cycle only.
  - DONE and TX_READY are both high in that cycle, so back-to-back accept is allowed there.
- Timing:
  - NBITS = DATA_W, or DATA_W+1 with the optional feature.
  - FRAME high for exactly 2*DIV*NBITS cycles; SCK shows exactly NBITS rising and NBITS falling edges.
  - Minimum spacing between accepts is 2*DIV*NBITS + DIV + 1 cycles.
- Bit order: MSB_FIRST selects the shift direction. Bit i of the frame is held for 2*DIV cycles, from SCK rise to the next bit's SCK rise.
- Counter widths: bit_cnt is clog2(NBITS+1) bits; the divider is clog2(DIV+1) bits. Neither counter wraps inside a frame.
- All outputs are registered; no combinational path from inputs to outputs except none. TX_READY is decoded from a state register.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN
- Defined: one even-parity bit (XOR of all latched data bits) is appended after the last data bit. NBITS = DATA_W+1, and timing formulas use this NBITS.
- Undefined: no parity logic is present and NBITS = DATA_W.

Test Plan:
- Reset then idle, DATA_W=8, DIV=2, MSB_FIRST=1: hold CLR_N=0 for 3 cycles, then release -> TX_READY=1, SCK=0, SDO=0, FRAME=0, DONE=0; outputs remain idle with TX_VALID=0.
- Single frame, TX_DATA=8'hA5 with one-cycle TX_VALID:
  - SDO sampled at each SCK fall = 1,0,1,0,0,1,0,1.
  - FRAME high 32 cycles, 8 SCK pulses each 2 high / 2 low.
  - GAP lasts 2 cycles, then a single DONE pulse.
- LSB first (MSB_FIRST=0), TX_DATA=8'h01 -> falling-edge samples = 1,0,0,0,0,0,0,0.
- Back-to-back: TX_VALID held high with 8'hFF then 8'h00 -> second accept happens in the DONE cycle; the second frame's FRAME rises on the next cycle; no word is lost or duplicated.
- Abort: pull CLR_N low during the 4th bit of 8'h3C -> SCK, SDO and FRAME go to 0 without waiting for CLK; no DONE. After release, a new frame 8'hC3 transmits correctly.
- SERIAL_TX_PARITY_EN defined:
  - 8'h07 -> 9 SCK pulses; 9th falling-edge sample = 1; FRAME high 36 cycles.
  - 8'h03 -> 9th sample = 0.
